// File: rtl/weight_loader.sv
// Streams packed 3x3 int8 kernel words into the 8-bank weight store, striping
// consecutive words round-robin across banks behind a registered write port.

module weight_loader_bank #(
  parameter int BANK = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs,
  input  logic [2:0] sel,
  output logic       wen
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wen <= 1'b0;
    else        wen <= hs && (sel == BANK[2:0]);
  end

endmodule

module weight_loader #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH:0]   cfg_rows,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [71:0]           s_data,
  input  logic                  s_last,
  output logic [7:0]            wen,
  output logic [71:0]           wdata,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int KW    = ADDR_WIDTH + 4;
  localparam int NBANK = 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   rows_q;
  logic [ADDR_WIDTH:0]   rows_m1;
  logic [KW-1:0]         k;
  logic [KW-1:0]         last_idx;
  logic [ADDR_WIDTH:0]   row;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  hs;
  logic                  last_word;
  logic                  end_job;
  logic                  err_q;

  assign s_ready = (state == S_LOAD);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign err     = err_q;

  assign hs        = s_ready && s_valid;
  assign rows_m1   = rows_q - 1'b1;
  assign last_idx  = {rows_m1, 3'b111};
  assign last_word = (k == last_idx);
  assign end_job   = hs && (s_last || last_word);

  // base + k/8 stays below 2*DEPTH, so one conditional subtract wraps it
  assign row      = k[KW-1:3];
  assign addr_sum = {1'b0, base_q} + row;
  always_comb begin
    addr = addr_sum[ADDR_WIDTH-1:0];
    if (addr_sum >= (ADDR_WIDTH+1)'(DEPTH))
      addr = ADDR_WIDTH'(addr_sum - (ADDR_WIDTH+1)'(DEPTH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // a zero-row job still passes through FLUSH so done keeps its fixed latency
      S_IDLE:  if (start) state_nxt = (cfg_rows != '0) ? S_LOAD : S_FLUSH;
      S_LOAD:  if (end_job) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      rows_q <= '0;
      k      <= '0;
      err_q  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        base_q <= cfg_base;
        rows_q <= cfg_rows;
        k      <= '0;
        err_q  <= 1'b0;
      end
    end else if (hs) begin
      k <= k + 1'b1;
      // s_last must coincide exactly with the final word; either mismatch is a framing error
      if (s_last != last_word) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata <= '0;
      waddr <= '0;
    end else if (hs) begin
      wdata <= s_data;
      waddr <= addr;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    weight_loader_bank #(.BANK(b)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .hs    (hs),
      .sel   (k[2:0]),
      .wen   (wen[b])
    );
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected writes are queued as words are
// accepted and retired by a negedge monitor on the write port.

module tb_weight_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW:0]   cfg_rows = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [71:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic [7:0]    wen;
  logic [71:0]   wdata;
  logic [AW-1:0] waddr;
  logic          busy, done, err;

  weight_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base),
    .cfg_rows(cfg_rows), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .wen(wen), .wdata(wdata),
    .waddr(waddr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    int          addr;
    logic [71:0] data;
  } exp_t;

  exp_t        sb[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          wr_cnt = 0;
  bit          mon_en = 1'b0;
  bit          prev_hs = 1'b0;
  bit          have_last = 1'b0;
  logic [71:0] last_data;
  logic [AW-1:0] last_addr;

  // write-port monitor
  always @(negedge clk) begin
    if (mon_en) begin
      chk_cnt++;
      if ((|wen) !== prev_hs)
        $display("FAIL wen_follows_hs: wen=%b prev_hs=%0d", wen, prev_hs);
      else pass_cnt++;
      if (|wen) begin
        int   b;
        exp_t e;
        wr_cnt++;
        b = -1;
        for (int i = 0; i < 8; i++) if (wen[i]) b = i;
        chk_cnt++;
        if (!$onehot(wen)) $display("FAIL wen_onehot: wen=%b", wen);
        else pass_cnt++;
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_write: bank=%0d addr=%0d data=%h", b, waddr, wdata);
        end else begin
          e = sb.pop_front();
          if (b !== e.bank || int'(waddr) !== e.addr || wdata !== e.data)
            $display("FAIL write: bank=%0d addr=%0d data=%h exp bank=%0d addr=%0d data=%h",
                     b, waddr, wdata, e.bank, e.addr, e.data);
          else pass_cnt++;
        end
        have_last = 1'b1;
        last_data = wdata;
        last_addr = waddr;
      end else if (have_last) begin
        chk_cnt++;
        if (wdata !== last_data || waddr !== last_addr)
          $display("FAIL port_hold: addr=%0d data=%h exp addr=%0d data=%h",
                   waddr, wdata, last_addr, last_data);
        else pass_cnt++;
      end
      prev_hs = s_valid && s_ready;
    end else begin
      prev_hs   = 1'b0;
      have_last = 1'b0;
    end
  end

  task automatic issue_start(input int base, input int rows);
    cfg_base = AW'(base);
    cfg_rows = (AW+1)'(rows);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One job: n words, s_last on word last_at (-1 = none), random gaps up to max_gap,
  // optional stray start pulse before word start_at.
  task automatic run_job(input string nm, input int base, input int rows, input int n,
                         input int last_at, input int max_gap, input int start_at,
                         input bit seq_data, input bit exp_err);
    int   w0;
    bit   ok;
    exp_t e;
    logic [71:0] d;
    w0 = wr_cnt;
    issue_start(base, rows);
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b1 || s_ready !== 1'b1)
      $display("FAIL %s start_latency: busy=%0d s_ready=%0d exp 1 1", nm, busy, s_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (i == start_at) begin
        s_valid = 1'b0;
        cfg_base = AW'(100);
        cfg_rows = (AW+1)'(3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        repeat (g) begin s_valid = 1'b0; @(posedge clk); #1; end
      end
      d = seq_data ? 72'(i) : {8'($urandom()), $urandom(), $urandom()};
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (i == last_at);
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (s_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        chk_cnt++;
        $display("FAIL %s accept_timeout: word=%0d s_ready=0 exp 1", nm, i);
        s_valid = 1'b0;
        return;
      end
      e.bank = i % 8;
      e.addr = (base + i / 8) % DEPTH;
      e.data = d;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (s_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s flush: s_ready=%0d done=%0d busy=%0d exp 0 0 1", nm, s_ready, done, busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b1 || err !== exp_err)
      $display("FAIL %s done: done=%0d err=%0d exp 1 %0d", nm, done, err, exp_err);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== exp_err)
      $display("FAIL %s idle: busy=%0d done=%0d err=%0d exp 0 0 %0d", nm, busy, done, err, exp_err);
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() != 0 || (wr_cnt - w0) != n)
      $display("FAIL %s write_count: writes=%0d pending=%0d exp %0d 0", nm, wr_cnt - w0, sb.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++;
    if (s_ready !== 0 || wen !== 0 || wdata !== 0 || waddr !== 0 || busy !== 0 || done !== 0 || err !== 0)
      $display("FAIL reset: s_ready=%0d wen=%b wdata=%h waddr=%0d busy=%0d done=%0d err=%0d exp all 0",
               s_ready, wen, wdata, waddr, busy, done, err);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #2;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_job("basic", 0, 2, 16, 15, 0, -1, 1'b1, 1'b0);
  endtask

  task automatic test_gaps();
    run_job("gaps", 0, 2, 16, 15, 3, -1, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    run_job("wrap", 1023, 2, 16, 15, 1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_early_last();
    run_job("early_last", 40, 1, 5, 4, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_missing_last();
    run_job("missing_last", 7, 1, 8, -1, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_zero_rows();
    int w0;
    w0 = wr_cnt;
    issue_start(3, 0);
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL zero_rows_t1: done=%0d s_ready=%0d busy=%0d exp 0 0 1", done, s_ready, busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b1 || err !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL zero_rows_t2: done=%0d err=%0d s_ready=%0d exp 1 0 0", done, err, s_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || (wr_cnt - w0) != 0)
      $display("FAIL zero_rows_t3: busy=%0d writes=%0d exp 0 0", busy, wr_cnt - w0);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_job();
    exp_t e;
    issue_start(0, 2);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 72'(100 + i);
      s_last  = 1'b0;
      e.bank = i; e.addr = 0; e.data = 72'(100 + i);
      sb.push_back(e);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk); #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_cnt++;
    if (s_ready !== 0 || wen !== 0 || wdata !== 0 || waddr !== 0 || busy !== 0 || done !== 0 || err !== 0)
      $display("FAIL reset_mid_job: s_ready=%0d wen=%b wdata=%h waddr=%0d busy=%0d done=%0d err=%0d exp all 0",
               s_ready, wen, wdata, waddr, busy, done, err);
    else pass_cnt++;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #2;
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_job("after_reset", 5, 1, 8, 7, 0, 3, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_early_last();
    test_missing_last();
    test_zero_rows();
    test_reset_mid_job();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
